// File: rtl/calc_op_sequencer_if.sv
// Command handshake, register-file ports, ALU control and result/flag status
// shared between calc_op_sequencer (slave) and its environment (master).
interface calc_op_sequencer_if #(
  parameter int DW = 9,
  parameter int RW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [RW-1:0] cmd_src1;
  logic [RW-1:0] cmd_src2;
  logic [RW-1:0] cmd_dst;
  logic          cmd_wb;
  logic [2:0]    cmd_opcode;
  logic [RW-1:0] reg_sel;
  logic [DW-1:0] reg_val;
  logic          assign_op1;
  logic          assign_op2;
  logic          alu_en;
  logic [2:0]    opcode;
  logic [DW-1:0] alu_result;
  logic          alu_oflag;
  logic          alu_sign;
  logic          wr_en;
  logic [RW-1:0] wr_num;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] res_data;
  logic          res_oflag;
  logic          res_sign;
  logic          done;
  logic          cmd_err;
  logic          ovf_sticky;
  logic          clr_flags;

  modport slave (
    input  cmd_valid, cmd_src1, cmd_src2, cmd_dst, cmd_wb, cmd_opcode,
    input  reg_val, alu_result, alu_oflag, alu_sign, clr_flags,
    output cmd_ready, reg_sel, assign_op1, assign_op2, alu_en, opcode,
    output wr_en, wr_num, wr_data, res_data, res_oflag, res_sign,
    output done, cmd_err, ovf_sticky
  );

  modport master (
    output cmd_valid, cmd_src1, cmd_src2, cmd_dst, cmd_wb, cmd_opcode,
    output reg_val, alu_result, alu_oflag, alu_sign, clr_flags,
    input  cmd_ready, reg_sel, assign_op1, assign_op2, alu_en, opcode,
    input  wr_en, wr_num, wr_data, res_data, res_oflag, res_sign,
    input  done, cmd_err, ovf_sticky
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// Sequences one ALU operation: read both operands, start the ALU, wait out its
// latency, capture result/flags, optionally write back. Macro CALC_SAT_EN saturates overflowed results.
module calc_op_sequencer #(
  parameter int DW       = 9,
  parameter int RW       = 3,
  parameter int NUM_REGS = 8,
  parameter int NUM_OPS  = 4,
  parameter int ALU_LAT  = 1
) (
  input logic                clk,
  input logic                rst,
  calc_op_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_RD2, S_EXEC, S_WAIT, S_WB, S_DONE
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

  state_t        r_state;
  logic [RW-1:0] r_src2;
  logic [RW-1:0] r_dst;
  logic          r_wb;
  logic [3:0]    r_cnt;

  logic          r_cmd_ready;
  logic [RW-1:0] r_reg_sel;
  logic          r_assign_op1;
  logic          r_assign_op2;
  logic          r_alu_en;
  logic [2:0]    r_opcode;
  logic          r_wr_en;
  logic [RW-1:0] r_wr_num;
  logic [DW-1:0] r_wr_data;
  logic [DW-1:0] r_res_data;
  logic          r_res_oflag;
  logic          r_res_sign;
  logic          r_done;
  logic          r_cmd_err;
  logic          r_ovf_sticky;

  logic          w_cmd_illegal;
  logic [DW-1:0] w_capture_data;

  // Register indices are compared as ints so out-of-range checks stay valid for any RW/NUM_REGS pairing.
  assign w_cmd_illegal = (int'(bus.cmd_src1) >= NUM_REGS) ||
                         (int'(bus.cmd_src2) >= NUM_REGS) ||
                         (bus.cmd_wb && (int'(bus.cmd_dst) >= NUM_REGS)) ||
                         (int'(bus.cmd_opcode) >= NUM_OPS);

`ifdef CALC_SAT_EN
  assign w_capture_data = !bus.alu_oflag ? bus.alu_result :
                          bus.alu_sign   ? {1'b1, {(DW-1){1'b0}}} :
                                           {1'b0, {(DW-1){1'b1}}};
`else
  assign w_capture_data = bus.alu_result;
`endif

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    if (rst) begin
      // NOTE: datapath/result registers are reset too, because every output must read 0 in reset.
      r_state      <= S_IDLE;
      r_src2       <= '0;
      r_dst        <= '0;
      r_wb         <= 1'b0;
      r_cnt        <= '0;
      r_cmd_ready  <= 1'b0;
      r_reg_sel    <= '0;
      r_assign_op1 <= 1'b0;
      r_assign_op2 <= 1'b0;
      r_alu_en     <= 1'b0;
      r_opcode     <= '0;
      r_wr_en      <= 1'b0;
      r_wr_num     <= '0;
      r_wr_data    <= '0;
      r_res_data   <= '0;
      r_res_oflag  <= 1'b0;
      r_res_sign   <= 1'b0;
      r_done       <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_assign_op1 <= 1'b0;
      r_assign_op2 <= 1'b0;
      r_alu_en     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_done       <= 1'b0;
      r_cmd_err    <= 1'b0;
      // A capture later in this block overrides the clear, so a same-cycle overflow wins.
      if (bus.clr_flags) r_ovf_sticky <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (bus.cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_src2      <= bus.cmd_src2;
            r_dst       <= bus.cmd_dst;
            r_wb        <= bus.cmd_wb;
            r_opcode    <= bus.cmd_opcode;
            if (w_cmd_illegal) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_cmd_err <= 1'b1;
            end else begin
              r_state      <= S_RD1;
              r_reg_sel    <= bus.cmd_src1;
              r_assign_op1 <= 1'b1;
            end
          end
        end
        S_RD1: begin
          r_state      <= S_RD2;
          r_reg_sel    <= r_src2;
          r_assign_op2 <= 1'b1;
        end
        S_RD2: begin
          r_state  <= S_EXEC;
          r_alu_en <= 1'b1;
        end
        S_EXEC: begin
          r_state <= S_WAIT;
          r_cnt   <= LAT_LOAD;
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state     <= S_WB;
            r_res_data  <= w_capture_data;
            r_res_oflag <= bus.alu_oflag;
            r_res_sign  <= bus.alu_sign;
            if (bus.alu_oflag) r_ovf_sticky <= 1'b1;
            r_wr_en     <= r_wb;
            r_wr_num    <= r_dst;
            r_wr_data   <= w_capture_data;
          end
        end
        S_WB: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.reg_sel    = r_reg_sel;
  assign bus.assign_op1 = r_assign_op1;
  assign bus.assign_op2 = r_assign_op2;
  assign bus.alu_en     = r_alu_en;
  assign bus.opcode     = r_opcode;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_num     = r_wr_num;
  assign bus.wr_data    = r_wr_data;
  assign bus.res_data   = r_res_data;
  assign bus.res_oflag  = r_res_oflag;
  assign bus.res_sign   = r_res_sign;
  assign bus.done       = r_done;
  assign bus.cmd_err    = r_cmd_err;
  assign bus.ovf_sticky = r_ovf_sticky;
endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: register file and ALU environment,
// a cycle-timeline reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_calc_op_sequencer;
  localparam int DW       = 9;
  localparam int RW       = 3;
  localparam int NUM_REGS = 8;
  localparam int NUM_OPS  = 4;
  localparam int LAT      = 3;
  localparam int GW       = DW + 2;
`ifdef CALC_SAT_EN
  localparam logic [DW-1:0] OVF_WR = 9'h0FF;
`else
  localparam logic [DW-1:0] OVF_WR = 9'h0A0;
`endif

  typedef struct packed {
    logic          ofl;
    logic          sgn;
    logic [DW-1:0] val;
  } alu_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_op_sequencer_if #(.DW(DW), .RW(RW)) bus ();

  calc_op_sequencer #(
    .DW(DW), .RW(RW), .NUM_REGS(NUM_REGS), .NUM_OPS(NUM_OPS), .ALU_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference ALU: 0 add, 1 sub, 2 and, 3 xor; signed overflow on add/sub.
  function automatic alu_t alu_fn(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    alu_t r;
    logic [DW-1:0] s;
    r = '0;
    case (op)
      3'd0: begin s = a + b; r.ofl = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]); end
      3'd1: begin s = a - b; r.ofl = (a[DW-1] != b[DW-1]) && (s[DW-1] != a[DW-1]); end
      3'd2: s = a & b;
      default: s = a ^ b;
    endcase
    r.val = s;
    r.sgn = s[DW-1];
    return r;
  endfunction

  function automatic logic [DW-1:0] stored_value(input alu_t r);
`ifdef CALC_SAT_EN
    if (r.ofl) return r.sgn ? DW'(1 << (DW-1)) : DW'((1 << (DW-1)) - 1);
`endif
    return r.val;
  endfunction

  // Environment: register file read port and an ALU that is valid only LAT cycles after alu_en.
  logic [DW-1:0] regs [NUM_REGS];
  logic [DW-1:0] alu_a, alu_b;
  logic [GW-1:0] garbage;
  int            alu_cnt;
  alu_t          alu_out;

  assign bus.reg_val = regs[bus.reg_sel];

  always @(posedge clk) begin
    if (bus.assign_op1) alu_a <= bus.reg_val;
    if (bus.assign_op2) alu_b <= bus.reg_val;
    if (rst)             alu_cnt <= 0;
    else if (bus.alu_en) alu_cnt <= LAT;
    else if (alu_cnt != 0) alu_cnt <= alu_cnt - 1;
    garbage <= GW'($urandom);
  end

  always_comb begin
    alu_out = alu_fn(bus.opcode, alu_a, alu_b);
    if (alu_cnt == 1) begin
      bus.alu_result = alu_out.val;
      bus.alu_oflag  = alu_out.ofl;
      bus.alu_sign   = alu_out.sgn;
    end else begin
      bus.alu_result = garbage[DW-1:0];
      bus.alu_oflag  = garbage[DW];
      bus.alu_sign   = garbage[DW+1];
    end
  end

  // Reference model: m_k is the cycle index since the accepting edge.
  bit            m_active, m_err, m_wb, m_wr_known;
  int            m_k;
  logic [RW-1:0] m_src1, m_src2, m_dst, m_reg_sel;
  logic [2:0]    m_op, m_opcode;
  logic          m_ready, m_res_oflag, m_res_sign, m_sticky;
  logic [DW-1:0] m_res_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    alu_t r;
    if (rst) begin
      m_active = 0; m_k = 0; m_ready = 0; m_reg_sel = '0; m_opcode = '0;
      m_res_data = '0; m_res_oflag = 0; m_res_sign = 0; m_sticky = 0; m_wr_known = 1;
      return;
    end
    if (bus.clr_flags) m_sticky = 0;
    if (m_active) begin
      if (!m_err && m_k == 3 + LAT) begin
        r = alu_fn(m_op, regs[m_src1], regs[m_src2]);
        m_res_data  = stored_value(r);
        m_res_oflag = r.ofl;
        m_res_sign  = r.sgn;
        if (r.ofl) m_sticky = 1;
      end
      if (m_k == (m_err ? 1 : 5 + LAT)) m_active = 0;
      else m_k++;
      if (m_active && !m_err && m_k == 2) m_reg_sel = m_src2;
      if (m_active && !m_err && m_k == 4 + LAT) m_wr_known = 0;
    end else if (m_ready && bus.cmd_valid) begin
      m_src1 = bus.cmd_src1; m_src2 = bus.cmd_src2; m_dst = bus.cmd_dst;
      m_wb = bus.cmd_wb; m_op = bus.cmd_opcode; m_opcode = bus.cmd_opcode;
      m_err = (int'(m_op) >= NUM_OPS) || (int'(m_src1) >= NUM_REGS) ||
              (int'(m_src2) >= NUM_REGS) || (m_wb && int'(m_dst) >= NUM_REGS);
      m_active = 1;
      m_k = 1;
      if (!m_err) m_reg_sel = m_src1;
    end
    m_ready = !m_active;
  endtask

  task automatic compare_all();
    bit e_run, e_wr, e_done;
    e_run  = m_active && !m_err;
    e_wr   = e_run && m_wb && m_k == 4 + LAT;
    e_done = m_active && m_k == (m_err ? 1 : 5 + LAT);
    check("cmd_ready",  32'(bus.cmd_ready),  32'(m_ready));
    check("reg_sel",    32'(bus.reg_sel),    32'(m_reg_sel));
    check("assign_op1", 32'(bus.assign_op1), 32'(e_run && m_k == 1));
    check("assign_op2", 32'(bus.assign_op2), 32'(e_run && m_k == 2));
    check("alu_en",     32'(bus.alu_en),     32'(e_run && m_k == 3));
    check("opcode",     32'(bus.opcode),     32'(m_opcode));
    check("wr_en",      32'(bus.wr_en),      32'(e_wr));
    check("done",       32'(bus.done),       32'(e_done));
    check("cmd_err",    32'(bus.cmd_err),    32'(e_done && m_err));
    check("res_data",   32'(bus.res_data),   32'(m_res_data));
    check("res_oflag",  32'(bus.res_oflag),  32'(m_res_oflag));
    check("res_sign",   32'(bus.res_sign),   32'(m_res_sign));
    check("ovf_sticky", 32'(bus.ovf_sticky), 32'(m_sticky));
    if (e_wr || m_wr_known) begin
      check("wr_num",  32'(bus.wr_num),  e_wr ? 32'(m_dst) : 32'd0);
      check("wr_data", 32'(bus.wr_data), e_wr ? 32'(m_res_data) : 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input int s1, input int s2, input int d, input int wb, input int op);
    bus.cmd_valid  = 1'b1;
    bus.cmd_src1   = RW'(s1);
    bus.cmd_src2   = RW'(s2);
    bus.cmd_dst    = RW'(d);
    bus.cmd_wb     = wb[0];
    bus.cmd_opcode = 3'(op);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_src1 = '0; bus.cmd_src2 = '0; bus.cmd_dst = '0;
    bus.cmd_wb = 1'b0; bus.cmd_opcode = '0; bus.clr_flags = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
    regs[2] = 9'd5; regs[3] = 9'd7; regs[6] = 9'h150;

    // Reset state
    repeat (2) tick();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    check("rst_res_data",  32'(bus.res_data),  0);
    check("rst_opcode",    32'(bus.opcode),    0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(bus.cmd_ready), 1);

    // Basic op: 5 + 7 into reg 4
    send(2, 3, 4, 1, 0);
    tick(); bus.cmd_valid = 1'b0;
    check("basic_c1_sel", 32'(bus.reg_sel), 2);
    check("basic_c1_op1", 32'(bus.assign_op1), 1);
    tick();
    check("basic_c2_sel", 32'(bus.reg_sel), 3);
    check("basic_c2_op2", 32'(bus.assign_op2), 1);
    tick();
    check("basic_c3_alu_en", 32'(bus.alu_en), 1);
    repeat (1 + LAT) tick();
    check("basic_wr_en",   32'(bus.wr_en), 1);
    check("basic_wr_num",  32'(bus.wr_num), 4);
    check("basic_wr_data", 32'(bus.wr_data), 'h00C);
    tick();
    check("basic_done", 32'(bus.done), 1);
    tick();
    check("basic_ready_back", 32'(bus.cmd_ready), 1);

    // Illegal opcode: error done in c1, result untouched
    send(1, 1, 1, 1, 5);
    tick(); bus.cmd_valid = 1'b0;
    check("ill_done",    32'(bus.done), 1);
    check("ill_cmd_err", 32'(bus.cmd_err), 1);
    check("ill_no_op1",  32'(bus.assign_op1), 0);
    check("ill_res",     32'(bus.res_data), 'h00C);
    tick();
    check("ill_ready", 32'(bus.cmd_ready), 1);

    // No write-back: 7 - 5
    send(3, 2, 5, 0, 1);
    tick(); bus.cmd_valid = 1'b0;
    repeat (3 + LAT) tick();
    check("nowb_wr_en", 32'(bus.wr_en), 0);
    tick();
    check("nowb_done", 32'(bus.done), 1);
    check("nowb_res",  32'(bus.res_data), 2);
    tick();

    // Overflow: 0x150 + 0x150 -> 0x0A0 with oflag, sign 0
    send(6, 6, 7, 1, 0);
    tick(); bus.cmd_valid = 1'b0;
    repeat (3 + LAT) tick();
    check("ovf_sticky_set", 32'(bus.ovf_sticky), 1);
    check("ovf_wr_data",    32'(bus.wr_data), 32'(OVF_WR));
    check("ovf_res_oflag",  32'(bus.res_oflag), 1);
    repeat (2) tick();
    bus.clr_flags = 1'b1;
    tick(); bus.clr_flags = 1'b0;
    check("ovf_cleared", 32'(bus.ovf_sticky), 0);

    // Set wins over a clear in the capture cycle
    send(6, 6, 7, 0, 0);
    tick(); bus.cmd_valid = 1'b0;
    repeat (2 + LAT) tick();
    bus.clr_flags = 1'b1;
    tick(); bus.clr_flags = 1'b0;
    check("set_wins", 32'(bus.ovf_sticky), 1);
    repeat (2) tick();

    // Mid-op reset during WAIT
    send(2, 3, 1, 1, 2);
    tick(); bus.cmd_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    check("mid_rst_wr_en",  32'(bus.wr_en), 0);
    check("mid_rst_done",   32'(bus.done), 0);
    check("mid_rst_sticky", 32'(bus.ovf_sticky), 0);
    check("mid_rst_sel",    32'(bus.reg_sel), 0);
    tick();
    check("mid_rst_ready", 32'(bus.cmd_ready), 1);

    // Back-to-back with valid held; second command's fields change during the first
    send(2, 3, 4, 1, 0);
    tick();
    send(3, 2, 5, 1, 1);
    repeat (7) tick();
    check("b2b_done1", 32'(bus.done), 1);
    tick();
    check("b2b_ready_c9", 32'(bus.cmd_ready), 1);
    tick(); bus.cmd_valid = 1'b0;
    check("b2b_c10_sel", 32'(bus.reg_sel), 3);
    repeat (6) tick();
    check("b2b_wr_en2",   32'(bus.wr_en), 1);
    check("b2b_wr_num2",  32'(bus.wr_num), 5);
    check("b2b_wr_data2", 32'(bus.wr_data), 2);
    tick();
    check("b2b_done2", 32'(bus.done), 1);
    tick();

    // Randomized traffic with aliasing, illegal opcodes, clears and rare resets
    for (int i = 0; i < NUM_REGS; i++) regs[i] = DW'($urandom);
    repeat (3000) begin
      bus.cmd_valid  = ($urandom_range(0, 3) != 0);
      bus.cmd_src1   = RW'($urandom);
      bus.cmd_src2   = RW'($urandom);
      bus.cmd_dst    = RW'($urandom);
      bus.cmd_wb     = 1'($urandom);
      bus.cmd_opcode = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      bus.clr_flags  = ($urandom_range(0, 15) == 0);
      rst            = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Command-driven controller that sequences one calculator operation through the shared register file read port, ALU and register file write port.
- Accepts a {src1, src2, dst, opcode} command over a valid/ready handshake. Drives the read-port select, ALU operand-load strobes and ALU enable, waits out the ALU latency, captures the result and flags, and optionally writes the result back.
- Sits between the keypad/decoder front end and the reg_file/alu pair. It replaces ad-hoc read sequencing with one arbitrated owner of the datapath.

Parameters:
- DW, 9, data width of register values and ALU result
- RW, 3, register index width
- NUM_REGS, 8, legal register indices 0..NUM_REGS-1
- NUM_OPS, 4, legal opcodes 0..NUM_OPS-1
- ALU_LAT, 1, cycles after the alu_en cycle before the ALU result is valid; legal range 1..15

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer idle, command accepted when valid&&ready at a rising edge
- cmd_src1  in  RW  register for operand 1
- cmd_src2  in  RW  register for operand 2
- cmd_dst  in  RW  write-back register
- cmd_wb  in  1  1 = write result to cmd_dst
- cmd_opcode  in  3  ALU opcode
- reg_sel  out  RW  register file read select
- reg_val  in  DW  register file read data (combinational)
- assign_op1  out  1  ALU latches reg_val as operand 1
- assign_op2  out  1  ALU latches reg_val as operand 2
- alu_en  out  1  ALU start strobe
- opcode  out  3  opcode to ALU, held for the whole operation
- alu_result  in  DW  ALU result
- alu_oflag  in  1  ALU overflow
- alu_sign  in  1  ALU sign
- wr_en  out  1  register file write strobe
- wr_num  out  RW  write index
- wr_data  out  DW  write data
- res_data  out  DW  captured result
- res_oflag  out  1  captured overflow
- res_sign  out  1  captured sign
- done  out  1  one-cycle completion pulse
- cmd_err  out  1  one-cycle illegal-command pulse, coincident with done
- ovf_sticky  out  1  set by any captured overflow
- clr_flags  in  1  clears ovf_sticky

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset state: IDLE. Every output is 0, including reg_sel, opcode, wr_num, wr_data, res_* and ovf_sticky. The exception is cmd_ready, which is 1 from the first cycle after reset.
- Reset mid-operation: abort immediately; no wr_en and no done are issued.
- States: IDLE, RD1, RD2, EXEC, WAIT, WB, DONE.
- IDLE:
  - cmd_ready=1. On valid&&ready, latch all cmd_* fields.
  - If src1, src2 or (when cmd_wb=1) dst is >= NUM_REGS, or cmd_opcode >= NUM_OPS: go to DONE with the error flag set.
  - Otherwise go to RD1.
- RD1: reg_sel=src1, assign_op1=1, then RD2.
- RD2: reg_sel=src2, assign_op2=1, then EXEC.
- EXEC: alu_en=1 for one cycle; load the wait counter with ALU_LAT-1; then WAIT.
- WAIT:
  - While the counter != 0, decrement it.
  - When the counter == 0: capture alu_result, alu_oflag and alu_sign into res_*; set ovf_sticky if alu_oflag; go to WB.
- WB: wr_en=cmd_wb, wr_num=dst, wr_data=res_data (registered), then DONE.
- DONE:
  - done=1. cmd_err=1 if the error flag is set.
  - Go to IDLE.
  - An erroring command leaves res_* unchanged.
- Hold values outside the active states:
  - reg_sel holds its last value outside RD1/RD2.
  - opcode is driven from the latched command from RD1 through DONE.
  - wr_en is 1 only in WB.
- Latency:
  - The accept edge ends cycle 0.
  - RD1 is c1, RD2 c2, EXEC c3, WAIT c4..c(3+ALU_LAT), WB c(4+ALU_LAT), DONE c(5+ALU_LAT).
  - cmd_ready returns in c(6+ALU_LAT).
  - With ALU_LAT=1: wr_en in c5, done in c6.
- Back-to-back commands: cmd_ready=0 from RD1 through DONE; a command held valid during DONE is accepted in the next IDLE cycle. No bubble beyond that one IDLE cycle.
- Register aliasing: src1==src2==dst is legal. Reads complete before the write, so there is no hazard.
- ovf_sticky priority: clr_flags and a new overflow capture in the same cycle leave ovf_sticky=1 (set wins). Reset clears it.
- Fields sampled: cmd fields are sampled only at accept; input changes afterward are ignored.

Optional Feature:
- Macro: CALC_SAT_EN.
- Defined: when the captured alu_oflag=1, wr_data and res_data are replaced by the saturated two's-complement limit instead of alu_result:
  - alu_sign=0: max positive, 9'h0FF for DW=9.
  - alu_sign=1: max negative, 9'h100 for DW=9.
  - res_oflag is still 1.
- Undefined: raw alu_result is passed through.

Test Plan:
- Basic op: reg2=5, reg3=7, cmd {src1=2, src2=3, dst=4, wb=1, opcode=0}, ALU returns 12 (9'h00C) -> assign_op1 with reg_sel=2 in c1; assign_op2 with reg_sel=3 in c2; alu_en in c3; wr_en with wr_num=4, wr_data=9'h00C in c5; done in c6; cmd_ready=1 in c7.
- Illegal opcode: cmd_opcode=5 with NUM_OPS=4 -> no assign/alu_en/wr_en; done=cmd_err=1 in c1; res_* unchanged.
- No write-back: wb=0 -> done in c6, wr_en never asserted, res_data=ALU value.
- Overflow: ALU returns 9'h0A0 with oflag=1, sign=0 -> ovf_sticky=1 from c5. Without the macro, wr_data=9'h0A0; with CALC_SAT_EN, wr_data=9'h0FF. clr_flags pulse -> ovf_sticky=0 next cycle.
- Mid-op reset: assert rst in c4 (WAIT) -> no wr_en, no done; all outputs 0 next cycle; cmd_ready=1 the cycle after rst deasserts.
- Back-to-back: cmd_valid held high with two commands, ALU_LAT=3 -> second accept at c9, second wr_en at c16, done pulses in c8 and c17.
